// File: rtl/md_ctrl.sv
// Sequencing controller for the multiply/divide unit: issues start pulses from E,
// tracks unit occupancy with its own latency counter, stalls D on hi/lo hazards.
module md_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   input  logic [31:0] instr_e,
   input  logic        req,
   input  logic        md_busy,
   output logic        md_start,
   output logic        stall_d,
   output logic        ctrl_busy,
   output logic        err,
   output logic [31:0] stall_cnt
);

   localparam logic [5:0] FUNC_MFHI  = 6'h10;
   localparam logic [5:0] FUNC_MTHI  = 6'h11;
   localparam logic [5:0] FUNC_MFLO  = 6'h12;
   localparam logic [5:0] FUNC_MTLO  = 6'h13;
   localparam logic [5:0] FUNC_MULT  = 6'h18;
   localparam logic [5:0] FUNC_MULTU = 6'h19;
   localparam logic [5:0] FUNC_DIV   = 6'h1a;
   localparam logic [5:0] FUNC_DIVU  = 6'h1b;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   function automatic logic is_mult(input logic [31:0] instr);
      return (instr[31:26] == 6'd0) &&
             ((instr[5:0] == FUNC_MULT) || (instr[5:0] == FUNC_MULTU));
   endfunction

   function automatic logic is_start(input logic [31:0] instr);
      return (instr[31:26] == 6'd0) &&
             ((instr[5:0] == FUNC_MULT) || (instr[5:0] == FUNC_MULTU) ||
              (instr[5:0] == FUNC_DIV)  || (instr[5:0] == FUNC_DIVU));
   endfunction

   function automatic logic is_access(input logic [31:0] instr);
      return (instr[31:26] == 6'd0) &&
             ((instr[5:0] == FUNC_MFHI) || (instr[5:0] == FUNC_MFLO) ||
              (instr[5:0] == FUNC_MTHI) || (instr[5:0] == FUNC_MTLO));
   endfunction

   state_t      state_r;
   logic [3:0]  cnt_r;
   logic        err_r;
   logic [31:0] stall_cnt_r;

   logic        start_e_s;
   logic        md_start_s;
   logic        stall_d_s;
   logic        collide_s;
   logic        unused_bits_s;

   assign unused_bits_s = ^{instr_d[25:6], instr_e[25:6]};

   // Start issue, D-stage hazard stall and start-while-busy detection
   always_comb begin
      start_e_s  = is_start(instr_e);
      md_start_s = 1'b0;
      stall_d_s  = 1'b0;
      collide_s  = 1'b0;
      if (!reset && (state_r == ST_IDLE) && start_e_s && !req) begin
         md_start_s = 1'b1;
      end else begin
         md_start_s = 1'b0;
      end
      if (!reset && is_access(instr_d) | is_start(instr_d)) begin
         stall_d_s = (state_r == ST_BUSY) || md_start_s;
      end else begin
         stall_d_s = 1'b0;
      end
      if ((state_r == ST_BUSY) && start_e_s && !req) begin
         collide_s = 1'b1;
      end else begin
         collide_s = 1'b0;
      end
   end

   // Occupancy FSM, sticky error flag and stall statistics
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'd0;
         err_r       <= 1'b0;
         stall_cnt_r <= 32'd0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (md_start_s) begin
                  state_r <= ST_BUSY;
                  cnt_r   <= is_mult(instr_e) ? MULT_N : DIV_N;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_BUSY: begin
               // req freezes the unit, so the counter holds with it
               if (!req) begin
                  if (cnt_r > 4'd1) begin
                     cnt_r <= cnt_r - 4'd1;
                  end else begin
                     state_r <= ST_IDLE;
                     cnt_r   <= 4'd0;
                  end
               end else begin
                  cnt_r <= cnt_r;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= 4'd0;
            end
         endcase
         if ((md_busy != (state_r == ST_BUSY)) || collide_s) begin
            err_r <= 1'b1;
         end else begin
            err_r <= err_r;
         end
         if (stall_d_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
      end
   end

   assign md_start  = md_start_s;
   assign stall_d   = stall_d_s;
   assign ctrl_busy = (state_r == ST_BUSY);
   assign err       = err_r;
   assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_md_ctrl.sv
// Self-checking bench for md_ctrl: a per-cycle reference model pushes expected
// outputs into a scoreboard queue that is drained against the DUT.
module tb_md_ctrl;

   localparam logic [5:0] F_MFHI  = 6'h10;
   localparam logic [5:0] F_MTHI  = 6'h11;
   localparam logic [5:0] F_MFLO  = 6'h12;
   localparam logic [5:0] F_MTLO  = 6'h13;
   localparam logic [5:0] F_MULT  = 6'h18;
   localparam logic [5:0] F_MULTU = 6'h19;
   localparam logic [5:0] F_DIV   = 6'h1a;
   localparam logic [5:0] F_DIVU  = 6'h1b;

   localparam logic [31:0] NOP   = 32'h0000_0000;
   localparam logic [31:0] MULT  = {26'd0, F_MULT};
   localparam logic [31:0] MULTU = {26'd0, F_MULTU};
   localparam logic [31:0] DIV   = {26'd0, F_DIV};
   localparam logic [31:0] DIVU  = {26'd0, F_DIVU};
   localparam logic [31:0] MFHI  = {26'd0, F_MFHI};
   localparam logic [31:0] MFLO  = {26'd0, F_MFLO};
   localparam logic [31:0] MTLO  = {26'd0, F_MTLO};
   localparam logic [31:0] LW_LIKE_MULT = {6'h23, 20'd0, F_MULT};

   logic        clk;
   logic        reset;
   logic [31:0] instr_d;
   logic [31:0] instr_e;
   logic        req;
   logic        md_busy;
   logic        md_start;
   logic        stall_d;
   logic        ctrl_busy;
   logic        err;
   logic [31:0] stall_cnt;

   md_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .instr_d(instr_d), .instr_e(instr_e),
      .req(req), .md_busy(md_busy), .md_start(md_start), .stall_d(stall_d),
      .ctrl_busy(ctrl_busy), .err(err), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        start;
      logic        stall;
      logic        busy;
      logic        err;
      logic [31:0] scnt;
   } exp_t;

   exp_t sb_q[$];

   int total_cnt = 0;
   int bad_cnt   = 0;
   int n_start, n_busy, n_stall;

   // reference model state
   logic        busy_m = 1'b0;
   logic [3:0]  cnt_m  = 4'd0;
   logic        err_m  = 1'b0;
   logic [31:0] scnt_m = 32'd0;
   logic        kill   = 1'b0;

   function automatic logic r_func(input logic [31:0] i, input logic [5:0] f);
      return (i[31:26] == 6'd0) && (i[5:0] == f);
   endfunction

   function automatic logic m_start(input logic [31:0] i);
      return r_func(i, F_MULT) || r_func(i, F_MULTU) || r_func(i, F_DIV) || r_func(i, F_DIVU);
   endfunction

   function automatic logic m_md(input logic [31:0] i);
      return m_start(i) || r_func(i, F_MFHI) || r_func(i, F_MFLO) ||
             r_func(i, F_MTHI) || r_func(i, F_MTLO);
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
      end
   endtask

   // one clock cycle: called just after a falling edge, returns at the next one
   task automatic step();
      exp_t e;
      exp_t o;
      logic st, sl;
      md_busy = busy_m && !kill;
      st = !reset && !busy_m && m_start(instr_e) && !req;
      sl = !reset && m_md(instr_d) && (busy_m || st);
      e.start = st; e.stall = sl; e.busy = busy_m; e.err = err_m; e.scnt = scnt_m;
      sb_q.push_back(e);
      #1;
      o = sb_q.pop_front();
      check_val("md_start", {31'd0, md_start}, {31'd0, o.start});
      check_val("stall_d", {31'd0, stall_d}, {31'd0, o.stall});
      check_val("ctrl_busy", {31'd0, ctrl_busy}, {31'd0, o.busy});
      check_val("err", {31'd0, err}, {31'd0, o.err});
      check_val("stall_cnt", stall_cnt, o.scnt);
      if (md_start) n_start++;
      if (ctrl_busy) n_busy++;
      if (stall_d) n_stall++;
      if (reset) begin
         busy_m = 1'b0; cnt_m = 4'd0; err_m = 1'b0; scnt_m = 32'd0;
      end else begin
         if ((md_busy != busy_m) || (busy_m && m_start(instr_e) && !req)) err_m = 1'b1;
         if (sl) scnt_m = scnt_m + 32'd1;
         if (st) begin
            busy_m = 1'b1;
            cnt_m  = (r_func(instr_e, F_MULT) || r_func(instr_e, F_MULTU)) ? 4'd5 : 4'd10;
         end else if (busy_m && !req) begin
            if (cnt_m > 4'd1) cnt_m = cnt_m - 4'd1;
            else begin busy_m = 1'b0; cnt_m = 4'd0; end
         end
      end
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; instr_d = NOP; instr_e = MULT; req = 1'b0; md_busy = 1'b0;
      @(negedge clk);
      // reset cycles with a START in E: nothing issued
      n_start = 0;
      repeat (2) step();
      check_val("reset_no_start", n_start, 0);
      reset = 1'b0;

      // plain mult: one start pulse, five busy cycles
      n_start = 0; n_busy = 0;
      instr_e = MULT; step();
      instr_e = NOP; repeat (7) step();
      check_val("mult_starts", n_start, 1);
      check_val("mult_busy_len", n_busy, 5);

      // divu in E with mfhi in D: 11 stall cycles, released on the 12th
      n_stall = 0;
      instr_d = MFHI; instr_e = DIVU; step();
      instr_e = NOP; repeat (10) step();
      check_val("divu_stall_len", n_stall, 11);
      step();
      check_val("mfhi_released", n_stall, 11);
      check_val("stall_cnt_11", stall_cnt, 32'd11);
      instr_d = NOP;

      // div frozen by req for 3 cycles starting at busy cycle 4
      n_busy = 0;
      instr_e = DIV; step();
      instr_e = NOP; repeat (3) step();
      req = 1'b1;
      repeat (3) begin
         check_val("cnt_hold", {28'd0, dut.cnt_r}, 32'd7);
         step();
      end
      req = 1'b0;
      repeat (10) step();
      check_val("div_req_busy_len", n_busy, 13);

      // START in E together with req: no issue, no stall on mflo
      n_start = 0;
      instr_e = MULT; instr_d = MFLO; req = 1'b1; step();
      check_val("req_idle", {31'd0, ctrl_busy}, 32'd0);
      req = 1'b0; instr_d = NOP;
      instr_e = LW_LIKE_MULT; step();
      instr_e = NOP; step();
      check_val("req_no_start", n_start, 0);

      // md_busy disagreement during busy cycle 2 of multu: sticky err
      instr_e = MULTU; step();
      instr_e = NOP; step();
      kill = 1'b1; step();
      kill = 1'b0;
      check_val("err_set", {31'd0, err}, 32'd1);
      repeat (5) step();
      check_val("err_sticky", {31'd0, err}, 32'd1);
      reset = 1'b1; step(); reset = 1'b0;
      check_val("err_cleared", {31'd0, err}, 32'd0);

      // START in E while busy flags err and does not disturb the operation
      n_busy = 0;
      instr_e = MULT; step();
      step();
      instr_e = NOP; repeat (6) step();
      check_val("collide_err", {31'd0, err}, 32'd1);
      check_val("collide_busy_len", n_busy, 5);

      // reset mid-div at cnt=6
      reset = 1'b1; step(); reset = 1'b0;
      instr_e = DIV; step();
      instr_e = NOP; repeat (4) step();
      check_val("cnt6", {28'd0, dut.cnt_r}, 32'd6);
      reset = 1'b1; step(); reset = 1'b0;
      check_val("rst_mid_busy", {31'd0, ctrl_busy}, 32'd0);
      step();

      // stall counter wrap
      force dut.stall_cnt_r = 32'hFFFF_FFFE;
      scnt_m = 32'hFFFF_FFFE;
      step();
      release dut.stall_cnt_r;
      instr_e = MULT; step();
      instr_e = NOP; instr_d = MTLO; repeat (3) step();
      instr_d = NOP; step();
      check_val("stall_wrap", stall_cnt, 32'h0000_0001);
      repeat (3) step();

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Sequencing controller for the pipeline's multiply/divide unit. It sits between decode (D) and execute (E). It issues the unit's `start` pulse for mult/multu/div/divu in E and tracks the unit's occupancy with its own latency counter. It stalls D while a hi/lo-touching instruction would collide with a running operation, and flags any disagreement with the unit's `busy`.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: cycles `busy` stays high after a mult/multu start edge. Legal range 1..15.
- `DIV_CYCLES`, default 10: cycles `busy` stays high after a div/divu start edge. Legal range 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `instr_d`  in  32  instruction in D stage.
- `instr_e`  in  32  instruction in E stage.
- `req`  in  1  interrupt/exception request. While high, the unit freezes, so this block freezes too.
- `md_busy`  in  1  `busy` output of the multiply/divide unit.
- `md_start`  out  1  start pulse to the unit (combinational).
- `stall_d`  out  1  freeze PC/D, insert bubble into E (combinational).
- `ctrl_busy`  out  1  internal occupancy (registered).
- `err`  out  1  sticky consistency error (registered).
- `stall_cnt`  out  32  count of cycles with `stall_d`=1 (registered).

## Operation
Instruction classes. Decoding uses op = bits 31:26 and func = bits 5:0 with the codebase func defines.
- START: op==0 and func is mult, multu, div or divu.
- ACCESS: op==0 and func is mfhi, mflo, mthi or mtlo.
- MD = START or ACCESS.

State is IDLE or BUSY, with a 4-bit counter `cnt`.

Start issue:
- `md_start` = !reset && state==IDLE && START(instr_e) && !req.

IDLE transitions:
- If `md_start`=1: go to BUSY. Load `cnt` with MULT_CYCLES for mult/multu, or DIV_CYCLES for div/divu.

BUSY transitions:
- `req`=1: hold `cnt` and state.
- `req`=0 and `cnt`>1: decrement `cnt`.
- `req`=0 and `cnt`==1: go to IDLE, set `cnt` to 0.

Outputs:
- `ctrl_busy` = (state==BUSY).
- `stall_d` = !reset && MD(instr_d) && (state==BUSY || `md_start`).

Error flag. `err` is set to 1 and held until reset when any of the following happens:
- In any non-reset cycle, `md_busy` != `ctrl_busy`.
- START(instr_e) occurs while state==BUSY and `req`=0. No start is issued and state is unaffected.

Stall counter:
- `stall_cnt` increments by 1 in every cycle with `stall_d`=1.
- It wraps from 0xFFFFFFFF to 0.
- It is not frozen by `req`.

## Timing
- Reset, synchronous: state IDLE, `cnt`=0, `ctrl_busy`=0, `err`=0, `stall_cnt`=0.
- `md_start`=0 and `stall_d`=0 during the reset cycle. `err` is not evaluated in the reset cycle.
- Start edge T: `md_start`=1 in the cycle ending at T. `ctrl_busy`=1 from T to T+N, where N is MULT_CYCLES or DIV_CYCLES, each extended by one cycle per `req`=1 cycle in that window. `ctrl_busy` is low again at the edge where `cnt` was 1.
- The first ACCESS in D may proceed in the cycle after `ctrl_busy` falls.
- Back-to-back starts: a START in E in the first IDLE cycle starts immediately. There is no dead cycle.
- `req`=1 in the same cycle as a START in E: no start is issued. The instruction is expected to be flushed.
- `req`=1 while BUSY: freeze. Resume counting when `req`=0.
- Reset mid-operation: returns to IDLE next edge regardless of `cnt`. The unit also resets, so there is no mismatch.
- ACCESS in D with IDLE state and no START in E: `stall_d`=0.

## Test plan
- Reset, then mult (op=0, func=mult) in E with `req`=0 → `md_start`=1 for 1 cycle. `ctrl_busy`=1 for exactly 5 cycles. Bench models `md_busy` identically → `err`=0.
- divu in E with mfhi in D the same cycle → `stall_d`=1 for 11 cycles (start cycle + 10 busy). `stall_cnt`=11 afterwards. mfhi released on cycle 12.
- div started, then `req`=1 for 3 cycles at busy cycle 4 → `ctrl_busy` stays high 13 cycles total. `cnt` holds at 7 during `req`.
- mult in E with `req`=1 → `md_start`=0, state stays IDLE. mflo in D → `stall_d`=0.
- `md_busy` forced to 0 during busy cycle 2 of a multu → `err`=1 next edge and stays 1 until `reset`. `reset` mid-div (cnt=6) → IDLE and `ctrl_busy`=0 next edge.
- `stall_cnt` preloaded near wrap (force 0xFFFFFFFE) plus 3 stall cycles → reads 0x00000001.
